hilo_ctrl: RTL and testbench

- Downstream companion of the multiply/divide unit in the P5 pipeline.
- Tracks multiply/divide latency and owns the architectural HI/LO registers.
- Commits the multiply/divide results when the operation completes and handles mthi/mtlo writes.
- Serves mfhi/mflo reads and generates the D-stage stall for HI/LO-dependent instructions while an operation is in flight.

---
 rtl/hilo_ctrl.sv | 126 ++++++++++++
 tb/tb_hilo_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register owner and multiply/divide latency tracker.
//
// Counts down the busy window of an issued mult/multu/div/divu, commits the
// unit's HI/LO results when the count expires, services mthi/mtlo writes while
// idle, and drives the D-stage stall for HI/LO-dependent instructions.
//
// Ports:
//   clk       system clock, all state updates on posedge
//   reset     synchronous active-low reset
//   start     E-stage multiply/divide issue strobe
//   md_op     000 mult, 001 multu, 010 div, 011 divu, 1xx invalid
//   xlu_hi    HI result from the multiply/divide unit (valid in final busy cycle)
//   xlu_lo    LO result from the multiply/divide unit (valid in final busy cycle)
//   mthi_en   E-stage mthi write enable
//   mtlo_en   E-stage mtlo write enable
//   wdata     mthi/mtlo write data
//   d_md_use  D-stage instruction depends on HI/LO or the multiply/divide unit
//   rd_sel    read select, 1 = HI, 0 = LO
//   busy      operation in flight (registered)
//   stall     freeze PC/F/D and bubble E (combinational)
//   done      one-cycle pulse in the cycle after commit
//   rdata     mfhi/mflo read data from committed registers
//   hi, lo    architectural HI/LO
module hilo_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] xlu_hi,
  input  logic [31:0] xlu_lo,
  input  logic        mthi_en,
  input  logic        mtlo_en,
  input  logic [31:0] wdata,
  input  logic        d_md_use,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_valid;
  logic [CNT_W-1:0]   lat_m1;

  // Decode the op into "accepted" and the countdown preload (LAT-1).
  always_comb begin
    op_valid = 1'b0;
    lat_m1   = '0;
    case (md_op)
      3'b000, 3'b001: begin
        op_valid = 1'b1;
        lat_m1   = CNT_W'(MULT_LAT - 1);
      end
      3'b010, 3'b011: begin
        op_valid = 1'b1;
        lat_m1   = CNT_W'(DIV_LAT - 1);
      end
      default: begin
        op_valid = 1'b0;
        lat_m1   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && op_valid) begin
            cnt   <= lat_m1;
            state <= RUN;
            busy  <= 1'b1;
          end else if (!start) begin
            // mthi/mtlo only land when no issue competes in the same cycle.
            if (mthi_en) hi <= wdata;
            if (mtlo_en) lo <= wdata;
          end
        end
        RUN: begin
          // start and mthi/mtlo are ignored here; stall keeps them from
          // reaching E legally while an operation is in flight.
          if (cnt == '0) begin
            hi    <= xlu_hi;
            lo    <= xlu_lo;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stall also covers the issue cycle itself, before busy has registered.
  assign stall = d_md_use & (busy | (start & op_valid));

  // No bypass: reads see only committed HI/LO.
  assign rdata = rd_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] xlu_hi, xlu_lo, wdata;
  logic        mthi_en, mtlo_en, d_md_use, rd_sel;
  logic        busy, stall, done;
  logic [31:0] rdata, hi, lo;

  int total = 0;
  int bad   = 0;

  hilo_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .xlu_hi(xlu_hi), .xlu_lo(xlu_lo), .mthi_en(mthi_en), .mtlo_en(mtlo_en),
    .wdata(wdata), .d_md_use(d_md_use), .rd_sel(rd_sel),
    .busy(busy), .stall(stall), .done(done), .rdata(rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'b000;
    xlu_hi = '0; xlu_lo = '0; wdata = '0;
    mthi_en = 1'b0; mtlo_en = 1'b0; d_md_use = 1'b0; rd_sel = 1'b0;

    // Reset held for two edges, then released.
    nx(); nx();
    reset = 1'b1; d_md_use = 1'b1;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    d_md_use = 1'b0;

    // mult: start sampled at the end of cycle 0.
    xlu_hi = 32'h0000_0001; xlu_lo = 32'hFFFF_FFFE;
    start = 1'b1; md_op = 3'b000;
    nx(); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("mult_busy_c%0d", c), {31'b0, busy}, 32'h1);
      chk($sformatf("mult_done_c%0d", c), {31'b0, done}, 32'h0);
      chk($sformatf("mult_hi_old_c%0d", c), hi, 32'h0);
      nx();
    end
    #1;
    chk("mult_busy_c6", {31'b0, busy}, 32'h0);
    chk("mult_done_c6", {31'b0, done}, 32'h1);
    chk("mult_hi", hi, 32'h0000_0001);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    xlu_hi = 32'hBAD0_BAD0; xlu_lo = 32'hBAD1_BAD1;
    nx(); #1;
    chk("mult_done_c7", {31'b0, done}, 32'h0);
    chk("mult_hi_kept", hi, 32'h0000_0001);

    // divu with a dependent mflo waiting in D.
    xlu_hi = 32'hAAAA_5555; xlu_lo = 32'h0F0F_0F0F;
    d_md_use = 1'b1; rd_sel = 1'b0;
    start = 1'b1; md_op = 3'b011;
    #1;
    chk("divu_stall_c0", {31'b0, stall}, 32'h1);
    nx(); start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("divu_stall_c%0d", c), {31'b0, stall}, 32'h1);
      chk($sformatf("divu_busy_c%0d", c), {31'b0, busy}, 32'h1);
      chk($sformatf("divu_rdata_old_c%0d", c), rdata, 32'hFFFF_FFFE);
      nx();
    end
    #1;
    chk("divu_stall_c11", {31'b0, stall}, 32'h0);
    chk("divu_done_c11", {31'b0, done}, 32'h1);
    chk("divu_rdata_lo", rdata, 32'h0F0F_0F0F);
    d_md_use = 1'b0;

    // mthi then mtlo in idle.
    nx();
    mthi_en = 1'b1; wdata = 32'h1234_5678;
    nx();
    mthi_en = 1'b0; mtlo_en = 1'b1; wdata = 32'h9ABC_DEF0; rd_sel = 1'b1;
    #1;
    chk("mthi_rd", rdata, 32'h1234_5678);
    nx();
    mtlo_en = 1'b0; rd_sel = 1'b0;
    #1;
    chk("mtlo_rd", rdata, 32'h9ABC_DEF0);
    rd_sel = 1'b1;
    #1;
    chk("mthi_rd2", rdata, 32'h1234_5678);

    // Writes with start or while busy are dropped; mult result still commits.
    xlu_hi = 32'h1111_1111; xlu_lo = 32'h2222_2222;
    start = 1'b1; md_op = 3'b000; mthi_en = 1'b1; wdata = 32'h5555_5555;
    nx();
    start = 1'b0; mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hDEAD_BEEF;
    nx();
    #1;
    chk("busywr_hi", hi, 32'h1234_5678);
    chk("busywr_lo", lo, 32'h9ABC_DEF0);
    mthi_en = 1'b0; mtlo_en = 1'b0;
    nx(); nx(); nx(); nx();
    #1;
    chk("busywr_done_c6", {31'b0, done}, 32'h1);
    chk("busywr_hi_commit", hi, 32'h1111_1111);
    chk("busywr_lo_commit", lo, 32'h2222_2222);

    // Both enables together in idle.
    mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hCAFE_F00D;
    nx();
    mthi_en = 1'b0; mtlo_en = 1'b0;
    #1;
    chk("both_hi", hi, 32'hCAFE_F00D);
    chk("both_lo", lo, 32'hCAFE_F00D);

    // Invalid op: no stall, no busy.
    d_md_use = 1'b1; start = 1'b1; md_op = 3'b100;
    #1;
    chk("inv_stall", {31'b0, stall}, 32'h0);
    nx();
    start = 1'b0; d_md_use = 1'b0;
    #1;
    chk("inv_busy", {31'b0, busy}, 32'h0);
    nx(); #1;
    chk("inv_busy2", {31'b0, busy}, 32'h0);

    // Start while busy is ignored: completion stays at cycle 6, one done.
    xlu_hi = 32'h3333_3333; xlu_lo = 32'h4444_4444;
    start = 1'b1; md_op = 3'b000;
    nx(); start = 1'b0;
    nx(); start = 1'b1; md_op = 3'b010;
    nx(); start = 1'b0;
    nx(); nx(); nx();
    #1;
    chk("sw_done_c6", {31'b0, done}, 32'h1);
    chk("sw_busy_c6", {31'b0, busy}, 32'h0);
    chk("sw_hi", hi, 32'h3333_3333);
    for (int c = 7; c <= 13; c++) begin
      nx(); #1;
      chk($sformatf("sw_busy_c%0d", c), {31'b0, busy}, 32'h0);
      chk($sformatf("sw_done_c%0d", c), {31'b0, done}, 32'h0);
    end

    // Back-to-back: start in the done cycle is accepted.
    xlu_hi = 32'h5A5A_0001; xlu_lo = 32'h5A5A_0002;
    start = 1'b1; md_op = 3'b001;
    nx(); start = 1'b0;
    nx(); nx(); nx(); nx(); nx();
    xlu_hi = 32'h6B6B_0003; xlu_lo = 32'h6B6B_0004;
    start = 1'b1; md_op = 3'b000;
    #1;
    chk("b2b_done_c6", {31'b0, done}, 32'h1);
    chk("b2b_busy_gap", {31'b0, busy}, 32'h0);
    chk("b2b_hi1", hi, 32'h5A5A_0001);
    nx(); start = 1'b0;
    #1;
    chk("b2b_busy_c7", {31'b0, busy}, 32'h1);
    nx(); nx(); nx(); nx();
    #1;
    chk("b2b_busy_c11", {31'b0, busy}, 32'h1);
    nx(); #1;
    chk("b2b_done_c12", {31'b0, done}, 32'h1);
    chk("b2b_lo2", lo, 32'h6B6B_0004);

    // Reset mid-div aborts without commit or done.
    xlu_hi = 32'h7777_7777; xlu_lo = 32'h8888_8888;
    start = 1'b1; md_op = 3'b010;
    nx(); start = 1'b0;
    nx(); nx(); nx();
    reset = 1'b0;
    nx(); reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    for (int c = 6; c <= 12; c++) begin
      nx(); #1;
      chk($sformatf("abort_done_c%0d", c), {31'b0, done}, 32'h0);
    end
    chk("abort_hi_end", hi, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
